beep_pattern: RTL and testbench

Parametrised buzzer pattern generator, successor to the single-tone beeper in the beep experiment. It produces a square-wave tone of runtime-selectable pitch, gated into a burst of N beeps with programmable on/off durations in milliseconds, or a continuous pattern until aborted. It sits between board-level control logic (keys, timers) and the buzzer pin, and reports busy and done for sequencing.

---
 rtl/beep_pkg.sv | 13 +
 rtl/beep_pattern_if.sv | 26 ++
 rtl/beep_tick_gen.sv | 30 +++
 rtl/beep_pattern.sv | 145 ++++++++++++++
 tb/tb_beep_pattern.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/beep_pkg.sv
// Shared types and constants for the beep pattern generator.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } beep_state_t;

  // Clock cycles per millisecond on the 50 MHz board clock.
  localparam int TICK_CYC_50MHZ = 50000;

endpackage

// File: rtl/beep_pattern_if.sv
// Control/status bundle between sequencing logic and the beep pattern generator.
interface beep_pattern_if #(
  parameter int DIV_W = 16,
  parameter int MS_W  = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] half_period;
  logic [MS_W-1:0]  on_ms;
  logic [MS_W-1:0]  off_ms;
  logic [CNT_W-1:0] count;
  logic             beep;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, half_period, on_ms, off_ms, count,
    input  beep, busy, done
  );

  modport slave (
    input  start, abort, half_period, on_ms, off_ms, count,
    output beep, busy, done
  );
endinterface

// File: rtl/beep_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_CYC clocks, restartable by clr.
module beep_tick_gen
  import beep_pkg::*;
#(
  parameter int TICK_CYC = TICK_CYC_50MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_CYC - 1);

  logic [PW-1:0] presc_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_p0 <= '0;
    end else if (clr || presc_p0 == LAST) begin
      presc_p0 <= '0;
    end else begin
      presc_p0 <= presc_p0 + PW'(1);
    end
  end

  assign tick = (presc_p0 == LAST);

endmodule

// File: rtl/beep_pattern.sv
// Buzzer burst generator: square-wave tone gated into N on/off beeps (N=0: until abort).
module beep_pattern
  import beep_pkg::*;
#(
  parameter int TICK_CYC = TICK_CYC_50MHZ,
  parameter int DIV_W    = 16,
  parameter int MS_W     = 16,
  parameter int CNT_W    = 4
) (
  input  logic    clk,
  input  logic    rst,
  beep_pattern_if.slave bus
);

  beep_state_t      state_p0;
  logic [DIV_W-1:0] hp_p0;
  logic [DIV_W-1:0] tone_p0;
  logic [MS_W-1:0]  on_dur_p0;
  logic [MS_W-1:0]  off_dur_p0;
  logic [MS_W-1:0]  ms_cnt_p0;
  logic [CNT_W-1:0] rem_p0;
  logic             cont_p0;
  logic             beep_p0;
  logic             busy_p0;
  logic             done_p0;

  logic tick;
  logic phase_end;
  logic presc_clr;

  // A zero duration would never match the ms counter, so it is run as 1 ms.
  function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] ms);
    return (ms == '0) ? MS_W'(1) : ms;
  endfunction

  always_comb begin
    phase_end = 1'b0;
    if (tick) begin
      if (state_p0 == ON)
        phase_end = (ms_cnt_p0 == on_dur_p0 - MS_W'(1));
      else if (state_p0 == OFF)
        phase_end = (ms_cnt_p0 == off_dur_p0 - MS_W'(1));
    end
    presc_clr = (state_p0 == IDLE) || phase_end || bus.abort;
  end

  beep_tick_gen #(
    .TICK_CYC (TICK_CYC)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0   <= IDLE;
      hp_p0      <= '0;
      tone_p0    <= '0;
      on_dur_p0  <= '0;
      off_dur_p0 <= '0;
      ms_cnt_p0  <= '0;
      rem_p0     <= '0;
      cont_p0    <= 1'b0;
      beep_p0    <= 1'b0;
      busy_p0    <= 1'b0;
      done_p0    <= 1'b0;
    end else begin
      done_p0 <= 1'b0;
      if (bus.abort) begin
        state_p0  <= IDLE;
        beep_p0   <= 1'b0;
        busy_p0   <= 1'b0;
        tone_p0   <= '0;
        ms_cnt_p0 <= '0;
      end else begin
        case (state_p0)
          IDLE: begin
            if (bus.start) begin
              hp_p0      <= bus.half_period;
              on_dur_p0  <= clamp_ms(bus.on_ms);
              off_dur_p0 <= clamp_ms(bus.off_ms);
              rem_p0     <= bus.count;
              cont_p0    <= (bus.count == '0);
              tone_p0    <= '0;
              ms_cnt_p0  <= '0;
              beep_p0    <= 1'b0;
              busy_p0    <= 1'b1;
              state_p0   <= ON;
            end
          end
          ON: begin
            if (phase_end) begin
              // Leaving ON silences the pin regardless of tone phase.
              beep_p0   <= 1'b0;
              tone_p0   <= '0;
              ms_cnt_p0 <= '0;
              if (!cont_p0 && rem_p0 == CNT_W'(1)) begin
                state_p0 <= IDLE;
                busy_p0  <= 1'b0;
                done_p0  <= 1'b1;
              end else begin
                state_p0 <= OFF;
              end
            end else begin
              if (tick)
                ms_cnt_p0 <= ms_cnt_p0 + MS_W'(1);
              if (hp_p0 != '0) begin
                if (tone_p0 == hp_p0 - DIV_W'(1)) begin
                  tone_p0 <= '0;
                  beep_p0 <= ~beep_p0;
                end else begin
                  tone_p0 <= tone_p0 + DIV_W'(1);
                end
              end
            end
          end
          OFF: begin
            beep_p0 <= 1'b0;
            if (phase_end) begin
              state_p0  <= ON;
              ms_cnt_p0 <= '0;
              tone_p0   <= '0;
              if (!cont_p0)
                rem_p0 <= rem_p0 - CNT_W'(1);
            end else if (tick) begin
              ms_cnt_p0 <= ms_cnt_p0 + MS_W'(1);
            end
          end
          default: begin
            state_p0 <= IDLE;
            busy_p0  <= 1'b0;
            beep_p0  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.beep = beep_p0;
  assign bus.busy = busy_p0;
  assign bus.done = done_p0;

endmodule

// File: tb/tb_beep_pattern.sv
// Bench for beep_pattern: timeline-formula reference model, per-cycle compare, directed scenarios.
module tb_beep_pattern;

  localparam int TICK = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  beep_pattern_if #(.DIV_W(16), .MS_W(16), .CNT_W(4)) bus ();

  beep_pattern #(
    .TICK_CYC (TICK),
    .DIV_W    (16),
    .MS_W     (16),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int k = 0;
  int dn_cnt = 0;
  int bh_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected outputs as a function of cycles since start.
  int m_hp, m_on, m_off, m_n, m_t;
  bit m_act = 1'b0;
  bit eb = 1'b0, ebusy = 1'b0, edone = 1'b0;

  function automatic void eval();
    int on_t, off_t, end_t, pos;
    on_t  = m_on * TICK;
    off_t = m_off * TICK;
    end_t = m_n * on_t + (m_n - 1) * off_t;
    if (m_n != 0 && m_t >= end_t) begin
      eb = 1'b0; ebusy = 1'b0; edone = (m_t == end_t); m_act = 1'b0;
    end else begin
      pos   = m_t % (on_t + off_t);
      ebusy = 1'b1;
      edone = 1'b0;
      eb    = (pos < on_t && m_hp != 0) ? (((pos / m_hp) % 2) == 1) : 1'b0;
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || bus.abort) begin
        m_act = 1'b0; eb = 1'b0; ebusy = 1'b0; edone = 1'b0;
      end else if (m_act) begin
        m_t++;
        eval();
      end else if (bus.start) begin
        m_hp  = int'(bus.half_period);
        m_on  = (bus.on_ms == 0) ? 1 : int'(bus.on_ms);
        m_off = (bus.off_ms == 0) ? 1 : int'(bus.off_ms);
        m_n   = int'(bus.count);
        m_t   = 0;
        m_act = 1'b1;
        eval();
      end else begin
        eb = 1'b0; ebusy = 1'b0; edone = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the model, plus activity counters.
  initial forever begin
    @(negedge clk);
    chk("beep", {31'd0, bus.beep}, {31'd0, eb});
    chk("busy", {31'd0, bus.busy}, {31'd0, ebusy});
    chk("done", {31'd0, bus.done}, {31'd0, edone});
    if (bus.done === 1'b1) dn_cnt++;
    if (bus.beep === 1'b1) bh_cnt++;
  end

  task automatic start_pat(input int hp, input int on, input int off, input int n);
    @(negedge clk);
    bus.half_period = 16'(hp);
    bus.on_ms       = 16'(on);
    bus.off_ms      = 16'(off);
    bus.count       = 4'(n);
    bus.abort       = 1'b0;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = cyc;
  endtask

  // which: 0 = beep high, 1 = done high, 2 = busy low. Bounded by limit cycles.
  task automatic wait_for(input int which, input int limit, input string name, input int exp);
    bit hit = 1'b0;
    while (!hit && (cyc - k) <= limit) begin
      case (which)
        0:       hit = (bus.beep === 1'b1);
        1:       hit = (bus.done === 1'b1);
        default: hit = (bus.busy === 1'b0);
      endcase
      if (!hit) @(negedge clk);
    end
    chk(name, 32'(cyc - k), 32'(exp));
  endtask

  int d0, b0;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.half_period = '0;
    bus.on_ms = '0;
    bus.off_ms = '0;
    bus.count = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_beep", {31'd0, bus.beep}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Burst of two
    d0 = dn_cnt;
    start_pat(3, 2, 1, 2);
    chk("burst_busy_at_k", {31'd0, bus.busy}, 32'd1);
    wait_for(0, 60, "burst_first_rise", 3);
    wait_for(1, 60, "burst_done_cycle", 50);
    chk("burst_busy_at_done", {31'd0, bus.busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("burst_done_count", 32'(dn_cnt - d0), 32'd1);

    // Continuous mode then abort
    d0 = dn_cnt;
    start_pat(2, 1, 1, 0);
    repeat (200) @(negedge clk);
    chk("cont_busy", {31'd0, bus.busy}, 32'd1);
    chk("cont_no_done", 32'(dn_cnt - d0), 32'd0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_beep", {31'd0, bus.beep}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);

    // Start while busy is ignored
    start_pat(4, 2, 1, 1);
    bus.start = 1'b1;
    bus.half_period = 16'd2;
    bus.on_ms = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_for(0, 30, "busy_start_rise", 4);
    wait_for(1, 40, "busy_start_done", 20);
    repeat (3) @(negedge clk);

    // Silent tone, and zero on-duration
    b0 = bh_cnt;
    start_pat(0, 1, 2, 2);
    wait_for(1, 60, "hp0_done", 40);
    chk("hp0_silent", 32'(bh_cnt - b0), 32'd0);
    start_pat(1, 0, 1, 1);
    wait_for(1, 30, "on0_done", 10);
    repeat (3) @(negedge clk);

    // Reset mid-pattern
    start_pat(3, 2, 2, 0);
    repeat (15) @(negedge clk);
    chk("pre_rst_beep", {31'd0, bus.beep}, 32'd1);
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_beep", {31'd0, bus.beep}, 32'd0);
    chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b0 = bh_cnt;
    repeat (30) @(negedge clk);
    chk("post_rst_idle", {31'd0, bus.busy}, 32'd0);
    chk("post_rst_quiet", 32'(bh_cnt - b0), 32'd0);

    // Start and abort together, then full-scale count
    @(negedge clk);
    bus.half_period = 16'd3;
    bus.on_ms = 16'd1;
    bus.off_ms = 16'd1;
    bus.count = 4'd2;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", {31'd0, bus.busy}, 32'd0);
    d0 = dn_cnt;
    start_pat(3, 1, 1, 15);
    wait_for(1, 320, "count15_done", 290);
    repeat (30) @(negedge clk);
    chk("count15_done_count", 32'(dn_cnt - d0), 32'd1);
    chk("count15_idle", {31'd0, bus.busy}, 32'd0);

    // Randomized patterns with noisy inputs, stray starts and aborts
    for (int it = 0; it < 16; it++) begin
      start_pat($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
      for (int c = 0; c < 300 && m_act; c++) begin
        @(negedge clk);
        bus.half_period = 16'($urandom_range(0, 7));
        bus.on_ms       = 16'($urandom_range(0, 3));
        bus.off_ms      = 16'($urandom_range(0, 3));
        bus.count       = 4'($urandom_range(0, 15));
        bus.start       = ($urandom_range(0, 15) == 0);
        bus.abort       = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
